// File: rtl/xor_stream_cipher_pkg.sv
// Shared types and constant helpers for the XOR stream cipher stage.
package xor_stream_cipher_pkg;

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} state_t;

  // Ceiling log2, never below 1 so every derived field has at least one bit.
  function automatic int LOG2_FUNC(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int ring_len(input int key_words);
    return 4 * key_words;
  endfunction

  function automatic int idx_width(input int key_words);
    return LOG2_FUNC(ring_len(key_words));
  endfunction

  // One-hot EOP mask: bit (ctrl_w-1-k) set means bytes 0..k are valid; zero means all valid.
  function automatic int eop_valid_cnt(input logic [31:0] ctrl, input int ctrl_w);
    int hi;
    hi = 0;
    if (ctrl == 32'd0) return ctrl_w;
    for (int b = 0; b < 32; b++)
      if (b < ctrl_w && ctrl[b]) hi = b;
    return ctrl_w - hi;
  endfunction

endpackage

// File: rtl/xor_stream_cipher_if.sv
// Word-wide data/ctrl/wr/rdy bus between user data path modules.
interface xor_stream_cipher_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/xor_stream_cipher_keystream_lane.sv
// Combinational per-word cipher: XORs eligible bytes with the key ring from a start index.
module xor_keystream_lane
  import xor_stream_cipher_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int KEY_WORDS  = 4,
  parameter int IDX_W      = idx_width(KEY_WORDS),
  parameter int OFS_W      = 9,
  parameter int CNT_W      = 4
) (
  input  logic [DATA_WIDTH-1:0]   word,
  input  logic [32*KEY_WORDS-1:0] key,
  input  logic [IDX_W-1:0]        start_idx,
  input  logic [OFS_W-1:0]        offset,
  input  logic [7:0]              skip,
  input  logic [CNT_W-1:0]        valid_cnt,
  input  logic                    enable,
  output logic [DATA_WIDTH-1:0]   out_word,
  output logic [CNT_W-1:0]        xor_cnt
);
  localparam int RING = ring_len(KEY_WORDS);

  logic [CTRL_WIDTH-1:0][7:0]       w_in, w_out;
  logic [RING-1:0][7:0]             ring;
  logic [CTRL_WIDTH-1:0]            hit;
  logic [CTRL_WIDTH-1:0][IDX_W-1:0] idx;

  assign w_in     = word;
  assign ring     = key;
  assign out_word = w_out;

  // Eligible bytes form one contiguous run, so each byte's ring index is the start plus the hits before it.
  always_comb begin
    logic [IDX_W-1:0] acc;
    logic [OFS_W-1:0] ofs;
    acc     = start_idx;
    ofs     = '0;
    xor_cnt = '0;
    hit     = '0;
    idx     = '0;
    for (int j = 0; j < CTRL_WIDTH; j++) begin
      ofs    = offset + OFS_W'(j);
      hit[j] = enable && (ofs >= OFS_W'(skip)) && (CNT_W'(j) < valid_cnt);
      idx[j] = acc;
      if (hit[j]) begin
        acc     = acc + IDX_W'(1);
        xor_cnt = xor_cnt + CNT_W'(1);
      end
    end
  end

  // Byte j sits MSB-first in the word; ring byte k lives at packed slot k^3 of the key.
  for (genvar j = 0; j < CTRL_WIDTH; j++) begin : g_byte
    assign w_out[CTRL_WIDTH-1-j] = hit[j] ? (w_in[CTRL_WIDTH-1-j] ^ ring[idx[j] ^ IDX_W'(3)])
                                          :  w_in[CTRL_WIDTH-1-j];
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// Packet XOR cipher stage: input fallthrough FIFO, header/body FSM, config latch, counters.
module xor_stream_cipher
  import xor_stream_cipher_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int KEY_WORDS       = 4,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  xor_stream_cipher_if.slave      in_if,
  xor_stream_cipher_if.master     out_if,
  input  logic                    cfg_enable,
  input  logic [7:0]              cfg_skip_bytes,
  input  logic [32*KEY_WORDS-1:0] cfg_key,
  output logic [31:0]             pkt_crypt_count,
  output logic [31:0]             byte_crypt_count
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int IDX_W = idx_width(KEY_WORDS);
  localparam int OFS_W = LOG2_FUNC(256 + 2 * CTRL_WIDTH);
  localparam int CNT_W = LOG2_FUNC(CTRL_WIDTH + 1);
  localparam logic [OFS_W-1:0] OFS_MAX = OFS_W'(255 + CTRL_WIDTH);

  // Input FIFO
  logic [DATA_WIDTH-1:0]    fifo_data [DEPTH];
  logic [CTRL_WIDTH-1:0]    fifo_ctrl [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wptr, rptr;
  logic [FIFO_DEPTH_BITS:0]   fcnt;
  logic push, pop, empty;

  assign empty     = (fcnt == '0);
  assign push      = in_if.wr && (fcnt != (FIFO_DEPTH_BITS+1)'(DEPTH));
  assign pop       = !empty && out_if.rdy;
  assign in_if.rdy = (fcnt < (FIFO_DEPTH_BITS+1)'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= in_if.data;
      fifo_ctrl[wptr] <= in_if.ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Packet state
  state_t                  state;
  logic                    hdr_open, en_q, any_xor;
  logic [7:0]              skip_q;
  logic [32*KEY_WORDS-1:0] key_q;
  logic [IDX_W-1:0]        idx_q;
  logic [OFS_W-1:0]        ofs_q;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [CTRL_WIDTH-1:0]   out_ctrl;
  logic                    out_wr;

  logic [DATA_WIDTH-1:0]   head_d, lane_word;
  logic [CTRL_WIDTH-1:0]   head_c;
  logic                    hdr_first, is_body, eff_en;
  logic [7:0]              eff_skip;
  logic [32*KEY_WORDS-1:0] eff_key;
  logic [OFS_W-1:0]        ofs_base, ofs_next;
  logic [CNT_W-1:0]        vcnt, xor_cnt;

  assign head_d = fifo_data[rptr];
  assign head_c = fifo_ctrl[rptr];

  // The first word of a packet is processed with the live config it is latching.
  assign hdr_first = (state == HDR) && !hdr_open;
  assign eff_en    = hdr_first ? cfg_enable     : en_q;
  assign eff_skip  = hdr_first ? cfg_skip_bytes : skip_q;
  assign eff_key   = hdr_first ? cfg_key        : key_q;
  assign is_body   = (state == BODY) || (head_c == '0);
  assign vcnt      = CNT_W'(eop_valid_cnt(32'(head_c), CTRL_WIDTH));
  assign ofs_base  = (state == BODY) ? ofs_q : '0;
  assign ofs_next  = (ofs_base > OFS_MAX - OFS_W'(CTRL_WIDTH)) ? OFS_MAX
                                                             : ofs_base + OFS_W'(CTRL_WIDTH);

  xor_keystream_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH),
    .KEY_WORDS  (KEY_WORDS),
    .IDX_W      (IDX_W),
    .OFS_W      (OFS_W),
    .CNT_W      (CNT_W)
  ) u_lane (
    .word      (head_d),
    .key       (eff_key),
    .start_idx ((state == BODY) ? idx_q : '0),
    .offset    (ofs_base),
    .skip      (eff_skip),
    .valid_cnt (vcnt),
    .enable    (eff_en && is_body),
    .out_word  (lane_word),
    .xor_cnt   (xor_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= HDR;
      hdr_open         <= 1'b0;
      en_q             <= 1'b0;
      skip_q           <= '0;
      key_q            <= '0;
      idx_q            <= '0;
      ofs_q            <= '0;
      any_xor          <= 1'b0;
      out_data         <= '0;
      out_ctrl         <= '0;
      out_wr           <= 1'b0;
      pkt_crypt_count  <= '0;
      byte_crypt_count <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data         <= lane_word;
        out_ctrl         <= head_c;
        byte_crypt_count <= byte_crypt_count + 32'(xor_cnt);
        if (hdr_first) begin
          en_q   <= cfg_enable;
          skip_q <= cfg_skip_bytes;
          key_q  <= cfg_key;
        end
        case (state)
          HDR: begin
            if (head_c != '0) begin
              hdr_open <= 1'b1;
            end else begin
              state    <= BODY;
              hdr_open <= 1'b0;
              ofs_q    <= ofs_next;
              idx_q    <= IDX_W'(xor_cnt);
              any_xor  <= (xor_cnt != '0);
            end
          end
          BODY: begin
            ofs_q   <= ofs_next;
            idx_q   <= idx_q + IDX_W'(xor_cnt);
            any_xor <= any_xor || (xor_cnt != '0);
            if (head_c != '0) begin
              state <= HDR;
              if (en_q && (any_xor || (xor_cnt != '0)))
                pkt_crypt_count <= pkt_crypt_count + 32'd1;
            end
          end
          default: state <= HDR;
        endcase
      end
    end
  end

  assign out_if.data = out_data;
  assign out_if.ctrl = out_ctrl;
  assign out_if.wr   = out_wr;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Randomized bench for xor_stream_cipher against a byte-level frame model.
module tb_xor_stream_cipher;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int KW = 2;
  localparam int R  = 4 * KW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xor_stream_cipher_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_if ();
  xor_stream_cipher_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_if ();

  logic          cfg_enable;
  logic [7:0]    cfg_skip_bytes;
  logic [32*KW-1:0] cfg_key;
  logic [31:0]   pkt_cnt, byte_cnt;
  logic          rdy_rand, rdy_fix, rnd_rdy;

  assign out_if.rdy = rdy_rand ? rnd_rdy : rdy_fix;

  xor_stream_cipher #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .KEY_WORDS(KW), .FIFO_DEPTH_BITS(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_if            (in_if),
    .out_if           (out_if),
    .cfg_enable       (cfg_enable),
    .cfg_skip_bytes   (cfg_skip_bytes),
    .cfg_key          (cfg_key),
    .pkt_crypt_count  (pkt_cnt),
    .byte_crypt_count (byte_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [63:0] pd[$];
  logic [7:0]  pc[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_c[$];
  int  exp_bytes = 0;
  int  exp_pkts  = 0;
  int  obs_cnt   = 0;
  bit  mon_on    = 1'b1;

  function automatic logic [7:0] ring_byte(input logic [63:0] key, input int k);
    return key[32*(k/4) + 8*(3 - k%4) +: 8];
  endfunction

  // Frame model: true byte offsets within the frame, key position = offset - skip.
  task automatic model_pkt(input bit en, input int skip, input logic [63:0] key,
                           input int lo, input int hi);
    int o = 0;
    int nx = 0;
    bit body = 1'b0;
    for (int w = lo; w < hi; w++) begin
      logic [63:0] d;
      int vc;
      d = pd[w];
      if (!body && pc[w] != 8'h00) begin
        exp_d.push_back(d);
        exp_c.push_back(pc[w]);
        continue;
      end
      body = 1'b1;
      vc = 8;
      if (pc[w] != 8'h00)
        for (int b = 0; b < 8; b++) if (pc[w][b]) vc = 8 - b;
      for (int j = 0; j < 8; j++) begin
        if (en && o >= skip && j < vc) begin
          d[63-8*j -: 8] = d[63-8*j -: 8] ^ ring_byte(key, (o - skip) % R);
          nx++;
        end
        o++;
      end
      exp_d.push_back(d);
      exp_c.push_back(pc[w]);
    end
    exp_bytes += nx;
    if (en && nx > 0) exp_pkts++;
  endtask

  task automatic build_pkt(input int nh, input int nd, input bit zero, input logic [7:0] mask);
    for (int i = 0; i < nh; i++) begin
      pd.push_back({$urandom, $urandom});
      pc.push_back(8'($urandom_range(1, 255)));
    end
    for (int i = 0; i < nd; i++) begin
      pd.push_back(zero ? 64'h0 : {$urandom, $urandom});
      pc.push_back((i == nd - 1) ? mask : 8'h00);
    end
  endtask

  task automatic send_pkt(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int t = 0;
      while (!in_if.rdy && t < 500) begin
        in_if.wr = 1'b0;
        @(negedge clk);
        t++;
      end
      if (t >= 500) begin
        chk("in_rdy_timeout", 64'(in_if.rdy), 64'd1);
        return;
      end
      in_if.data = pd[i];
      in_if.ctrl = pc[i];
      in_if.wr   = 1'b1;
      @(negedge clk);
    end
    in_if.wr = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int t = 0;
    while (exp_d.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk({tag, "_drain"}, 64'(exp_d.size()), 64'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_bytes"}, 64'(byte_cnt), 64'(exp_bytes));
    chk({tag, "_pkts"},  64'(pkt_cnt),  64'(exp_pkts));
  endtask

  always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  always @(negedge clk) begin
    if (mon_on && out_if.wr) begin
      obs_cnt++;
      if (exp_d.size() == 0) chk("unexpected_wr", 64'(out_if.wr), 64'd0);
      else begin
        chk("out_data", out_if.data, exp_d.pop_front());
        chk("out_ctrl", 64'(out_if.ctrl), 64'(exp_c.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] key_a, key_b;
    int n, base, t, sk;
    bit en;
    reset = 1'b1;
    in_if.wr = 1'b0; in_if.data = '0; in_if.ctrl = '0;
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    cfg_enable = 1'b0; cfg_skip_bytes = 8'd0; cfg_key = '0;
    #12;
    chk("rst_out_wr",   64'(out_if.wr),   64'd0);
    chk("rst_out_data", out_if.data,      64'd0);
    chk("rst_out_ctrl", 64'(out_if.ctrl), 64'd0);
    chk("rst_pkt",      64'(pkt_cnt),     64'd0);
    chk("rst_byte",     64'(byte_cnt),    64'd0);
    chk("rst_in_rdy",   64'(in_if.rdy),   64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed: skip 34 over a zero frame, then same frame with the cipher off.
    cfg_key = {32'h89abcdef, 32'h01234567};
    cfg_enable = 1'b1; cfg_skip_bytes = 8'd34;
    pd.delete(); pc.delete();
    build_pkt(1, 6, 1'b1, 8'h01);
    model_pkt(1'b1, 34, cfg_key, 0, pd.size());
    send_pkt(0, pd.size());
    drain_and_check("skip34");
    cfg_enable = 1'b0;
    model_pkt(1'b0, 34, cfg_key, 0, pd.size());
    send_pkt(0, pd.size());
    drain_and_check("disabled");

    // Partial EOP mask with skip 0 and an all-ones key.
    cfg_enable = 1'b1; cfg_skip_bytes = 8'd0; cfg_key = '1;
    pd.delete(); pc.delete();
    build_pkt(1, 2, 1'b1, 8'h08);
    pd[2] = 64'h0123456789abcdef;
    model_pkt(1'b1, 0, cfg_key, 0, pd.size());
    send_pkt(0, pd.size());
    drain_and_check("eop_mask");

    // Downstream stall with a full FIFO.
    cfg_key = {$urandom, $urandom}; cfg_skip_bytes = 8'd5;
    pd.delete(); pc.delete();
    build_pkt(1, 6, 1'b0, 8'h04);
    model_pkt(1'b1, 5, cfg_key, 0, pd.size());
    rdy_fix = 1'b0;
    n = 0;
    while (n < pd.size() && in_if.rdy) begin
      in_if.data = pd[n]; in_if.ctrl = pc[n]; in_if.wr = 1'b1;
      @(negedge clk);
      n++;
    end
    in_if.wr = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_rdy", 64'(in_if.rdy), 64'd0);
      chk("stall_out_wr", 64'(out_if.wr), 64'd0);
    end
    rdy_fix = 1'b1;
    send_pkt(n, pd.size());
    drain_and_check("stall");

    // Key change mid-packet takes effect on the following packet.
    rdy_rand = 1'b1;
    key_a = {$urandom, $urandom}; key_b = {$urandom, $urandom};
    sk = $urandom_range(0, 10);
    cfg_key = key_a; cfg_skip_bytes = 8'(sk);
    pd.delete(); pc.delete();
    build_pkt(1, 6, 1'b0, 8'h10);
    model_pkt(1'b1, sk, key_a, 0, pd.size());
    base = obs_cnt;
    send_pkt(0, 3);
    t = 0;
    while (obs_cnt < base + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("keychg_wait", 64'(obs_cnt - base), 64'd2);
    cfg_key = key_b;
    send_pkt(3, pd.size());
    drain_and_check("key_old");
    pd.delete(); pc.delete();
    build_pkt(2, 4, 1'b0, 8'h80);
    model_pkt(1'b1, sk, key_b, 0, pd.size());
    send_pkt(0, pd.size());
    drain_and_check("key_new");

    // Back-to-back packets, second one without headers.
    pd.delete(); pc.delete();
    build_pkt(1, 3, 1'b0, 8'h02);
    n = pd.size();
    build_pkt(0, 3, 1'b0, 8'h40);
    model_pkt(1'b1, sk, key_b, 0, n);
    model_pkt(1'b1, sk, key_b, n, pd.size());
    send_pkt(0, pd.size());
    drain_and_check("b2b");

    // Random packets, including skips beyond the frame.
    for (int p = 0; p < 12; p++) begin
      en = ($urandom_range(0, 3) != 0);
      sk = ($urandom_range(0, 4) == 0) ? 200 : $urandom_range(0, 40);
      cfg_enable = en; cfg_skip_bytes = 8'(sk); cfg_key = {$urandom, $urandom};
      pd.delete(); pc.delete();
      build_pkt($urandom_range(0, 2), $urandom_range(2, 7), 1'b0, 8'(1 << $urandom_range(0, 7)));
      model_pkt(en, sk, cfg_key, 0, pd.size());
      send_pkt(0, pd.size());
      drain_and_check("rand");
    end

    // Reset mid-packet, then a fresh packet from keystream index 0.
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    cfg_enable = 1'b1; cfg_skip_bytes = 8'd3; cfg_key = {$urandom, $urandom};
    mon_on = 1'b0;
    pd.delete(); pc.delete();
    build_pkt(1, 5, 1'b0, 8'h01);
    send_pkt(0, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_wr", 64'(out_if.wr), 64'd0);
    chk("midrst_pkt",    64'(pkt_cnt),   64'd0);
    chk("midrst_byte",   64'(byte_cnt),  64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_d.delete(); exp_c.delete();
    exp_bytes = 0; exp_pkts = 0;
    mon_on = 1'b1;
    @(negedge clk);
    pd.delete(); pc.delete();
    build_pkt(1, 4, 1'b0, 8'h20);
    model_pkt(1'b1, 3, cfg_key, 0, pd.size());
    send_pkt(0, pd.size());
    drain_and_check("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
